multi_edge_sync: RTL and testbench

- Parametrised receive-side synchroniser for N asynchronous single-bit event lines landing in one clock domain.
- Per channel:
  - configurable-depth synchroniser;
  - stability (glitch) filter;
  - mode-selectable edge detector (rise / fall / both / off);
  - saturating event counter with sticky overflow.
- Sits in the audio cortex wherever external strobes or cross-domain flags must become clean one-cycle pulses plus event statistics.

---
 rtl/multi_edge_sync_pkg.sv | 23 ++
 rtl/multi_edge_sync_if.sv | 24 ++
 rtl/multi_edge_sync_chan.sv | 123 ++++++++++++
 rtl/multi_edge_sync.sv | 43 ++++
 tb/tb_multi_edge_sync.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multi_edge_sync_pkg.sv
// Shared definitions for the multi-channel edge synchroniser: edge-detect modes
// and the lower bounds every parameter set must respect.
package multi_edge_sync_pkg;

   typedef enum logic [1:0] {
      MODE_OFF  = 2'b00,
      MODE_RISE = 2'b01,
      MODE_FALL = 2'b10,
      MODE_BOTH = 2'b11
   } mode_e;

   localparam int MIN_NO_OF_CHANNELS = 1;
   localparam int MIN_SYNC_STAGES    = 2;
   localparam int MIN_FILTER_LEN     = 1;
   localparam int MIN_CNT_W          = 2;

   function automatic logic params_ok(input int no_of_channels, input int sync_stages,
                                      input int filter_len, input int cnt_w);
      return (no_of_channels >= MIN_NO_OF_CHANNELS) && (sync_stages >= MIN_SYNC_STAGES) &&
             (filter_len >= MIN_FILTER_LEN) && (cnt_w >= MIN_CNT_W);
   endfunction

endpackage

// File: rtl/multi_edge_sync_if.sv
// Bundle of the per-channel event inputs, controls and status outputs of
// multi_edge_sync; the slave modport is the synchroniser side.
interface multi_edge_sync_if #(
   parameter int P_NO_OF_CHANNELS = 4,
   parameter int P_CNT_W          = 8
);
   logic [P_NO_OF_CHANNELS-1:0]         async_in_ih;
   logic [2*P_NO_OF_CHANNELS-1:0]       mode_i;
   logic [P_NO_OF_CHANNELS-1:0]         cnt_clr_ih;
   logic [P_NO_OF_CHANNELS-1:0]         level_oh;
   logic [P_NO_OF_CHANNELS-1:0]         pulse_oh;
   logic [P_CNT_W*P_NO_OF_CHANNELS-1:0] cnt_od;
   logic [P_NO_OF_CHANNELS-1:0]         ovf_oh;

   modport master (
      output async_in_ih, mode_i, cnt_clr_ih,
      input  level_oh, pulse_oh, cnt_od, ovf_oh
   );

   modport slave (
      input  async_in_ih, mode_i, cnt_clr_ih,
      output level_oh, pulse_oh, cnt_od, ovf_oh
   );
endinterface

// File: rtl/multi_edge_sync_chan.sv
// One event channel: synchroniser chain, stability filter, mode-gated edge
// detector and saturating event counter with sticky overflow.
module edge_sync_chan
   import multi_edge_sync_pkg::*;
#(
   parameter int P_SYNC_STAGES = 2,
   parameter int P_FILTER_LEN  = 3,
   parameter int P_CNT_W       = 8
) (
   input  logic               clk_ir,
   input  logic               rst_ih,
   input  logic               async_ih,
   input  logic [1:0]         mode_i,
   input  logic               cnt_clr_ih,
   output logic               level_oh,
   output logic               pulse_oh,
   output logic [P_CNT_W-1:0] cnt_od,
   output logic               ovf_oh
);

   localparam logic [P_CNT_W-1:0] CNT_MAX = {P_CNT_W{1'b1}};
   localparam logic [P_CNT_W-1:0] CNT_ONE = {{(P_CNT_W-1){1'b0}}, 1'b1};

   logic [P_SYNC_STAGES-1:0] sync_r;
   logic [P_FILTER_LEN-1:0]  hist_r;
   logic [P_FILTER_LEN-1:0]  hist_nxt_s;
   logic                     sync_s;
   logic                     rise_s;
   logic                     fall_s;
   logic                     qual_s;
   logic                     level_r;
   logic                     pulse_r;
   logic [P_CNT_W-1:0]       cnt_r;
   logic                     ovf_r;

   assign sync_s = sync_r[P_SYNC_STAGES-1];

   generate
      if (P_FILTER_LEN == 1) begin : g_hist_single
         assign hist_nxt_s = sync_s;
      end else begin : g_hist_shift
         assign hist_nxt_s = {hist_r[P_FILTER_LEN-2:0], sync_s};
      end
   endgenerate

   // Metastability chain; only its last stage is used downstream.
   always_ff @(posedge clk_ir or posedge rst_ih) begin
      if (rst_ih) begin
         sync_r <= '0;
      end else begin
         sync_r <= {sync_r[P_SYNC_STAGES-2:0], async_ih};
      end
   end

   // Level change requests and their qualification by the channel mode.
   always_comb begin
      rise_s = 1'b0;
      fall_s = 1'b0;
      qual_s = 1'b0;
      if (&hist_r) begin
         rise_s = ~level_r;
      end else begin
         rise_s = 1'b0;
      end
      if (~|hist_r) begin
         fall_s = level_r;
      end else begin
         fall_s = 1'b0;
      end
      case (mode_e'(mode_i))
         MODE_OFF:  qual_s = 1'b0;
         MODE_RISE: qual_s = rise_s;
         MODE_FALL: qual_s = fall_s;
         MODE_BOTH: qual_s = rise_s | fall_s;
         default:   qual_s = 1'b0;
      endcase
   end

   // Filter history, filtered level and the edge pulse that accompanies it.
   always_ff @(posedge clk_ir or posedge rst_ih) begin
      if (rst_ih) begin
         hist_r  <= '0;
         level_r <= 1'b0;
         pulse_r <= 1'b0;
      end else begin
         hist_r  <= hist_nxt_s;
         pulse_r <= qual_s;
         if (rise_s) begin
            level_r <= 1'b1;
         end else if (fall_s) begin
            level_r <= 1'b0;
         end else begin
            level_r <= level_r;
         end
      end
   end

   // Counter follows the visible pulse; a clear that meets a pulse keeps that pulse.
   always_ff @(posedge clk_ir or posedge rst_ih) begin
      if (rst_ih) begin
         cnt_r <= '0;
         ovf_r <= 1'b0;
      end else if (cnt_clr_ih) begin
         cnt_r <= pulse_r ? CNT_ONE : '0;
         ovf_r <= 1'b0;
      end else if (pulse_r) begin
         if (cnt_r == CNT_MAX) begin
            ovf_r <= 1'b1;
         end else begin
            cnt_r <= cnt_r + CNT_ONE;
         end
      end else begin
         cnt_r <= cnt_r;
         ovf_r <= ovf_r;
      end
   end

   assign level_oh = level_r;
   assign pulse_oh = pulse_r;
   assign cnt_od   = cnt_r;
   assign ovf_oh   = ovf_r;

endmodule

// File: rtl/multi_edge_sync.sv
// Receive-side synchroniser for N independent asynchronous event lines; each
// channel is a self-contained edge_sync_chan sliced onto the shared buses.
module multi_edge_sync
   import multi_edge_sync_pkg::*;
#(
   parameter int P_NO_OF_CHANNELS = 4,
   parameter int P_SYNC_STAGES    = 2,
   parameter int P_FILTER_LEN     = 3,
   parameter int P_CNT_W          = 8
) (
   input logic              clk_ir,
   input logic              rst_ih,
   multi_edge_sync_if.slave bus
);

   generate
      if (!params_ok(P_NO_OF_CHANNELS, P_SYNC_STAGES, P_FILTER_LEN, P_CNT_W)) begin : g_param_err
         $error("multi_edge_sync: parameter below its minimum value");
      end
   endgenerate

   genvar i;
   generate
      for (i = 0; i < P_NO_OF_CHANNELS; i++) begin : g_chan
         edge_sync_chan #(
            .P_SYNC_STAGES (P_SYNC_STAGES),
            .P_FILTER_LEN  (P_FILTER_LEN),
            .P_CNT_W       (P_CNT_W)
         ) u_chan (
            .clk_ir     (clk_ir),
            .rst_ih     (rst_ih),
            .async_ih   (bus.async_in_ih[i]),
            .mode_i     (bus.mode_i[2*i+1:2*i]),
            .cnt_clr_ih (bus.cnt_clr_ih[i]),
            .level_oh   (bus.level_oh[i]),
            .pulse_oh   (bus.pulse_oh[i]),
            .cnt_od     (bus.cnt_od[i*P_CNT_W +: P_CNT_W]),
            .ovf_oh     (bus.ovf_oh[i])
         );
      end
   endgenerate

endmodule

// File: tb/tb_multi_edge_sync.sv
// Self-checking bench for multi_edge_sync: a default 4-channel instance with a
// pulse scoreboard, plus a 1-channel 2-bit-counter instance for saturation.
module tb_multi_edge_sync;

   logic clk_ir = 1'b0;
   logic rst_ih = 1'b1;
   always #5 clk_ir = ~clk_ir;

   multi_edge_sync_if #(.P_NO_OF_CHANNELS(4), .P_CNT_W(8)) bus_a ();
   multi_edge_sync_if #(.P_NO_OF_CHANNELS(1), .P_CNT_W(2)) bus_b ();

   multi_edge_sync #(.P_NO_OF_CHANNELS(4), .P_SYNC_STAGES(2), .P_FILTER_LEN(3), .P_CNT_W(8))
      u_dut_a (.clk_ir(clk_ir), .rst_ih(rst_ih), .bus(bus_a));
   multi_edge_sync #(.P_NO_OF_CHANNELS(1), .P_SYNC_STAGES(2), .P_FILTER_LEN(3), .P_CNT_W(2))
      u_dut_b (.clk_ir(clk_ir), .rst_ih(rst_ih), .bus(bus_b));

   int   tests_run    = 0;
   int   tests_failed = 0;
   logic exp_q [4][$];
   int   pulse_cnt [4];
   bit   chk_en = 1'b1;
   logic mon_exp;

   // Scoreboard: every pulse on the wide instance must match a queued expected level.
   always @(negedge clk_ir) begin
      if (!rst_ih) begin
         for (int c = 0; c < 4; c++) begin
            if (bus_a.pulse_oh[c] === 1'b1) begin
               pulse_cnt[c]++;
               if (chk_en) begin
                  tests_run++;
                  if (exp_q[c].size() == 0) begin
                     tests_failed++;
                     $display("FAIL unexpected_pulse ch%0d: got pulse, required none", c);
                  end else begin
                     mon_exp = exp_q[c].pop_front();
                     if (bus_a.level_oh[c] !== mon_exp) begin
                        tests_failed++;
                        $display("FAIL pulse_level ch%0d: got %b, required %b", c, bus_a.level_oh[c], mon_exp);
                     end
                  end
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk_ir);
      #1;
   endtask

   task automatic test_reset();
      bus_a.async_in_ih = 4'h0; bus_a.mode_i = 8'h00; bus_a.cnt_clr_ih = 4'h0;
      bus_b.async_in_ih = 1'b0; bus_b.mode_i = 2'b00; bus_b.cnt_clr_ih = 1'b0;
      rst_ih = 1'b1;
      repeat (3) tick();
      tests_run++;
      if ({bus_a.level_oh, bus_a.pulse_oh, bus_a.cnt_od, bus_a.ovf_oh} !== 44'h0) begin
         tests_failed++;
         $display("FAIL reset_a: got %h, required 0", {bus_a.level_oh, bus_a.pulse_oh, bus_a.cnt_od, bus_a.ovf_oh});
      end
      tests_run++;
      if ({bus_b.level_oh, bus_b.pulse_oh, bus_b.cnt_od, bus_b.ovf_oh} !== 5'h0) begin
         tests_failed++;
         $display("FAIL reset_b: got %h, required 0", {bus_b.level_oh, bus_b.pulse_oh, bus_b.cnt_od, bus_b.ovf_oh});
      end
      rst_ih = 1'b0;
      repeat (4) tick();
   endtask

   task automatic test_rise();
      int lat = 0;
      int npulse = 0;
      bus_a.mode_i = 8'b00_00_00_01;
      exp_q[0].push_back(1'b1);
      bus_a.async_in_ih[0] = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (bus_a.pulse_oh[0] === 1'b1) begin
            npulse++;
            if (lat == 0) lat = k;
         end
      end
      tests_run++;
      if (lat < 6 || lat > 7) begin
         tests_failed++;
         $display("FAIL rise_latency: got %0d, required 6 or 7", lat);
      end
      tests_run++;
      if (npulse != 1) begin
         tests_failed++;
         $display("FAIL rise_pulse_count: got %0d, required 1", npulse);
      end
      tests_run++;
      if (bus_a.level_oh[0] !== 1'b1 || bus_a.cnt_od[7:0] !== 8'd1) begin
         tests_failed++;
         $display("FAIL rise_level_cnt: got level %b cnt %0d, required 1 and 1", bus_a.level_oh[0], bus_a.cnt_od[7:0]);
      end
      bus_a.async_in_ih[0] = 1'b0;
      repeat (12) tick();
      tests_run++;
      if (bus_a.level_oh[0] !== 1'b0 || bus_a.cnt_od[7:0] !== 8'd1 || exp_q[0].size() != 0) begin
         tests_failed++;
         $display("FAIL fall_in_rise_mode: got level %b cnt %0d pending %0d, required 0 1 0",
                  bus_a.level_oh[0], bus_a.cnt_od[7:0], exp_q[0].size());
      end
   endtask

   task automatic test_glitch();
      bus_a.mode_i = 8'b00_00_00_11;
      bus_a.async_in_ih[0] = 1'b1;
      repeat (2) tick();
      bus_a.async_in_ih[0] = 1'b0;
      repeat (12) tick();
      tests_run++;
      if (bus_a.level_oh[0] !== 1'b0 || bus_a.cnt_od[7:0] !== 8'd1) begin
         tests_failed++;
         $display("FAIL glitch_rejected: got level %b cnt %0d, required 0 1", bus_a.level_oh[0], bus_a.cnt_od[7:0]);
      end
      exp_q[0].push_back(1'b1);
      exp_q[0].push_back(1'b0);
      bus_a.async_in_ih[0] = 1'b1;
      repeat (3) tick();
      bus_a.async_in_ih[0] = 1'b0;
      repeat (14) tick();
      tests_run++;
      if (bus_a.cnt_od[7:0] !== 8'd3 || bus_a.level_oh[0] !== 1'b0 || exp_q[0].size() != 0) begin
         tests_failed++;
         $display("FAIL min_width_both: got cnt %0d level %b pending %0d, required 3 0 0",
                  bus_a.cnt_od[7:0], bus_a.level_oh[0], exp_q[0].size());
      end
   endtask

   task automatic test_modes();
      logic v;
      bus_a.mode_i = 8'b00_00_10_00;
      pulse_cnt[2] = 0;
      for (int p = 0; p < 4; p++) begin
         v = (p % 2 == 0) ? 1'b1 : 1'b0;
         if (v == 1'b0) exp_q[1].push_back(1'b0);
         bus_a.async_in_ih[1] = v;
         bus_a.async_in_ih[2] = v;
         repeat (9) tick();
         tests_run++;
         if (bus_a.level_oh[1] !== v || bus_a.level_oh[2] !== v) begin
            tests_failed++;
            $display("FAIL mode_level_track step%0d: got ch1 %b ch2 %b, required %b", p,
                     bus_a.level_oh[1], bus_a.level_oh[2], v);
         end
      end
      tests_run++;
      if (bus_a.cnt_od[15:8] !== 8'd2 || bus_a.cnt_od[23:16] !== 8'd0 || pulse_cnt[2] != 0 || exp_q[1].size() != 0) begin
         tests_failed++;
         $display("FAIL mode_counts: got ch1 %0d ch2 %0d ch2_pulses %0d pending %0d, required 2 0 0 0",
                  bus_a.cnt_od[15:8], bus_a.cnt_od[23:16], pulse_cnt[2], exp_q[1].size());
      end
   endtask

   task automatic test_saturate();
      logic [1:0] exp_cnt;
      logic       exp_ovf;
      int         waited = 0;
      bus_b.mode_i = 2'b01;
      for (int k = 1; k <= 5; k++) begin
         bus_b.async_in_ih = 1'b1;
         repeat (9) tick();
         bus_b.async_in_ih = 1'b0;
         repeat (9) tick();
         exp_cnt = (k > 3) ? 2'd3 : 2'(k);
         exp_ovf = (k >= 4);
         tests_run++;
         if (bus_b.cnt_od !== exp_cnt || bus_b.ovf_oh !== exp_ovf) begin
            tests_failed++;
            $display("FAIL saturate event%0d: got cnt %0d ovf %b, required %0d %b", k,
                     bus_b.cnt_od, bus_b.ovf_oh, exp_cnt, exp_ovf);
         end
      end
      bus_b.async_in_ih = 1'b1;
      while (bus_b.pulse_oh !== 1'b1 && waited < 12) begin
         tick();
         waited++;
      end
      tests_run++;
      if (bus_b.pulse_oh !== 1'b1) begin
         tests_failed++;
         $display("FAIL sixth_pulse_timeout: got no pulse in %0d cycles, required a pulse", waited);
      end
      bus_b.cnt_clr_ih = 1'b1;
      tick();
      bus_b.cnt_clr_ih = 1'b0;
      tests_run++;
      if (bus_b.cnt_od !== 2'd1 || bus_b.ovf_oh !== 1'b0) begin
         tests_failed++;
         $display("FAIL clear_with_pulse: got cnt %0d ovf %b, required 1 0", bus_b.cnt_od, bus_b.ovf_oh);
      end
      bus_b.async_in_ih = 1'b0;
      repeat (10) tick();
   endtask

   task automatic test_reset_mid();
      int lat = 0;
      bus_a.mode_i = 8'b00_00_00_01;
      bus_a.async_in_ih[0] = 1'b1;
      repeat (2) tick();
      #3 rst_ih = 1'b1;
      #1;
      tests_run++;
      if ({bus_a.level_oh, bus_a.pulse_oh, bus_a.cnt_od, bus_a.ovf_oh, bus_b.cnt_od, bus_b.ovf_oh} !== 47'h0) begin
         tests_failed++;
         $display("FAIL async_reset: got a %h b %h, required 0",
                  {bus_a.level_oh, bus_a.pulse_oh, bus_a.cnt_od, bus_a.ovf_oh}, {bus_b.cnt_od, bus_b.ovf_oh});
      end
      repeat (2) tick();
      rst_ih = 1'b0;
      exp_q[0].push_back(1'b1);
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (bus_a.pulse_oh[0] === 1'b1 && lat == 0) lat = k;
      end
      tests_run++;
      if (lat < 6 || lat > 7 || exp_q[0].size() != 0) begin
         tests_failed++;
         $display("FAIL release_high_latency: got %0d pending %0d, required 6 or 7 and 0", lat, exp_q[0].size());
      end
      bus_a.async_in_ih[0] = 1'b0;
      repeat (12) tick();
   endtask

   task automatic test_random();
      logic [3:0] x = 4'h0;
      logic       lvl [4];
      logic       prev [4];
      int         run [4];
      int         edges [4];
      logic [7:0] exp_cnt;
      chk_en = 1'b0;
      bus_a.mode_i = 8'hFF;
      bus_a.async_in_ih = 4'h0;
      repeat (12) tick();
      bus_a.cnt_clr_ih = 4'hF;
      tick();
      bus_a.cnt_clr_ih = 4'h0;
      for (int c = 0; c < 4; c++) begin
         lvl[c] = 1'b0; prev[c] = 1'b0; run[c] = 3; edges[c] = 0; pulse_cnt[c] = 0;
      end
      for (int t = 0; t < 420; t++) begin
         if (t < 400) begin
            for (int c = 0; c < 4; c++) begin
               if ($urandom_range(0, 3) == 0) x[c] = ~x[c];
            end
         end
         bus_a.async_in_ih = x;
         for (int c = 0; c < 4; c++) begin
            run[c] = (x[c] == prev[c]) ? run[c] + 1 : 1;
            prev[c] = x[c];
            if (run[c] >= 3 && x[c] != lvl[c]) begin
               lvl[c] = x[c];
               edges[c]++;
            end
         end
         tick();
      end
      repeat (4) tick();
      for (int c = 0; c < 4; c++) begin
         exp_cnt = (edges[c] > 255) ? 8'd255 : 8'(edges[c]);
         tests_run++;
         if (pulse_cnt[c] != edges[c] || bus_a.cnt_od[c*8 +: 8] !== exp_cnt || bus_a.level_oh[c] !== lvl[c]) begin
            tests_failed++;
            $display("FAIL random ch%0d: got pulses %0d cnt %0d level %b, required %0d %0d %b", c,
                     pulse_cnt[c], bus_a.cnt_od[c*8 +: 8], bus_a.level_oh[c], edges[c], exp_cnt, lvl[c]);
         end
      end
      chk_en = 1'b1;
   endtask

   initial begin
      for (int c = 0; c < 4; c++) pulse_cnt[c] = 0;
      test_reset();
      test_rise();
      test_glitch();
      test_modes();
      test_saturate();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
